// File: rtl/fetch_sequencer_if.sv
// Handshake bundle between the fetch sequencer, instruction memory and decode.
// The master modport is the sequencer side; slave is the surrounding environment.
interface fetch_sequencer_if #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 32
) ();
    logic              start;
    logic              halt;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_instr;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_instr;
    logic [ADDR_W-1:0] out_pc;
    logic              running;

    modport master (
        input  start, halt, redirect_valid, redirect_pc, imem_instr, out_ready,
        output imem_addr, out_valid, out_instr, out_pc, running
    );

    modport slave (
        output start, halt, redirect_valid, redirect_pc, imem_instr, out_ready,
        input  imem_addr, out_valid, out_instr, out_pc, running
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Program counter plus prefetch FIFO feeding {pc, instr} to decode over valid/ready.
// Supports start/halt control and branch redirect with a full FIFO flush.
module fetch_sequencer #(
    parameter int unsigned       ADDR_W     = 6,
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       FIFO_DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    fetch_sequencer_if.master bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {StIdle, StRun, StHalted} state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_fifo_instr [FIFO_DEPTH];
    logic [ADDR_W-1:0] r_fifo_pc    [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_last_instr;
    logic [ADDR_W-1:0] r_last_pc;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_pop   = ~w_empty & bus.out_ready & ~bus.redirect_valid;
    assign w_push  = (r_state == StRun) & ~bus.redirect_valid & (~w_full | w_pop);

    assign bus.imem_addr = r_pc;
    assign bus.running   = (r_state == StRun);
    assign bus.out_valid = ~w_empty & ~bus.redirect_valid;
    // When empty, keep showing the most recently consumed head.
    assign bus.out_instr = w_empty ? r_last_instr : r_fifo_instr[r_rptr];
    assign bus.out_pc    = w_empty ? r_last_pc    : r_fifo_pc[r_rptr];

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:   if (bus.start) w_state_next = StRun;
            StRun:    if (bus.halt)  w_state_next = StHalted;
            StHalted: if (bus.start) w_state_next = StRun;
            default:  w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (bus.redirect_valid) begin
            r_pc <= bus.redirect_pc;
        end else if (w_push) begin
            r_pc <= r_pc + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_instr[i] <= '0;
                r_fifo_pc[i]    <= '0;
            end
        end else if (w_push) begin
            r_fifo_instr[r_wptr] <= bus.imem_instr;
            r_fifo_pc[r_wptr]    <= r_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (bus.redirect_valid) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_instr <= '0;
            r_last_pc    <= '0;
        end else if (w_pop) begin
            r_last_instr <= r_fifo_instr[r_rptr];
            r_last_pc    <= r_fifo_pc[r_rptr];
        end
    end
endmodule
